// File: rtl/hyper_xface_wrapper.sv
// HyperRAM-style transaction engine with an embedded dword memory and CR0/CR1 registers.
// Each request runs CA, optional latency, then 4-cycle data groups; all outputs are registered.
module hyper_xface_wrapper #(
    parameter int DEPTH     = 1024,
    parameter int CA_CYCLES = 6
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_rd_req,
    input  logic        i_wr_req,
    input  logic        i_mem_or_reg,
    input  logic [3:0]  i_wr_byte_en,
    input  logic [5:0]  i_rd_num_dwords,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wr_d,
    output logic [31:0] o_rd_d,
    output logic        o_rd_rdy,
    output logic        o_busy,
    output logic        o_burst_wr_rdy,
    input  logic [7:0]  i_latency_1x,
    input  logic [7:0]  i_latency_2x
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [7:0] CA_LAST = 8'(CA_CYCLES - 1);
    localparam logic [7:0] DATA_LAST = 8'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CA,
        S_LAT,
        S_DATA
    } state_t;

    state_t        r_state;
    logic [7:0]    r_cnt;
    logic [7:0]    r_lat;
    logic          r_is_wr;
    logic          r_mem_or_reg;
    logic [3:0]    r_byte_en;
    logic [31:0]   r_wr_d;
    logic [AW-1:0] r_addr;
    logic [5:0]    r_dw_left;
    logic [15:0]   r_cr0;
    logic [15:0]   r_cr1;
    logic [31:0]   r_mem [DEPTH];

    logic          w_req;
    logic [7:0]    w_lat;
    logic [5:0]    w_dw_last;
    logic          w_group_end;
    logic          w_commit;
    logic [31:0]   w_mem_rdata;
    logic [31:0]   w_reg_rdata;
    logic          w_unused_addr;

    assign w_unused_addr = ^i_addr[31:AW];

    assign w_req = i_rd_req | i_wr_req;

    // Register writes carry no latency; register reads use the 1x latency.
    always_comb begin
        w_lat = i_latency_2x;
        if (i_mem_or_reg) begin
            w_lat = i_wr_req ? 8'd0 : i_latency_1x;
        end
    end

    assign w_dw_last = (i_wr_req || i_mem_or_reg || i_rd_num_dwords == 6'd0) ?
                       6'd0 : (i_rd_num_dwords - 6'd1);

    assign w_group_end = (r_state == S_DATA) && (r_cnt == 8'd0);
    assign w_commit    = i_reset && w_group_end && r_is_wr && !r_mem_or_reg;
    assign w_mem_rdata = r_mem[r_addr];
    assign w_reg_rdata = {16'h0000, r_addr[0] ? r_cr1 : r_cr0};

    always_ff @(posedge i_clk) begin
        if (w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (r_byte_en[i]) begin
                    r_mem[r_addr][8*i +: 8] <= r_wr_d[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state        <= S_IDLE;
            r_cnt          <= 8'd0;
            r_lat          <= 8'd0;
            r_is_wr        <= 1'b0;
            r_mem_or_reg   <= 1'b0;
            r_byte_en      <= 4'd0;
            r_wr_d         <= 32'd0;
            r_addr         <= '0;
            r_dw_left      <= 6'd0;
            r_cr0          <= 16'h8F1F;
            r_cr1          <= 16'h0002;
            o_rd_d         <= 32'd0;
            o_rd_rdy       <= 1'b0;
            o_busy         <= 1'b0;
            o_burst_wr_rdy <= 1'b0;
        end else begin
            o_rd_rdy       <= 1'b0;
            o_burst_wr_rdy <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_is_wr      <= i_wr_req;
                        r_mem_or_reg <= i_mem_or_reg;
                        r_byte_en    <= i_wr_byte_en;
                        r_wr_d       <= i_wr_d;
                        r_addr       <= i_addr[AW-1:0];
                        r_dw_left    <= w_dw_last;
                        r_lat        <= w_lat;
                        r_cnt        <= CA_LAST;
                        r_state      <= S_CA;
                        o_busy       <= 1'b1;
                    end
                end
                S_CA: begin
                    if (r_cnt != 8'd0) begin
                        r_cnt <= r_cnt - 8'd1;
                    end else if (r_lat != 8'd0) begin
                        r_cnt   <= r_lat - 8'd1;
                        r_state <= S_LAT;
                    end else begin
                        r_cnt   <= DATA_LAST;
                        r_state <= S_DATA;
                    end
                end
                S_LAT: begin
                    if (r_cnt != 8'd0) begin
                        r_cnt <= r_cnt - 8'd1;
                    end else begin
                        r_cnt   <= DATA_LAST;
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (r_cnt != 8'd0) begin
                        r_cnt <= r_cnt - 8'd1;
                    end else if (r_is_wr) begin
                        if (r_mem_or_reg) begin
                            if (r_addr[0]) begin
                                r_cr1 <= r_wr_d[15:0];
                            end else begin
                                r_cr0 <= r_wr_d[15:0];
                            end
                        end
                        o_burst_wr_rdy <= 1'b1;
                        o_busy         <= 1'b0;
                        r_state        <= S_IDLE;
                    end else begin
                        o_rd_d   <= r_mem_or_reg ? w_reg_rdata : w_mem_rdata;
                        o_rd_rdy <= 1'b1;
                        if (r_dw_left == 6'd0) begin
                            o_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            // Burst address wraps naturally in the AW-bit register.
                            r_dw_left <= r_dw_left - 6'd1;
                            r_addr    <= r_addr + 1'b1;
                            r_cnt     <= DATA_LAST;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hyper_xface_wrapper.sv
// Directed bench for hyper_xface_wrapper: reset values, register/memory reads and writes,
// byte masks, wrapping bursts, request arbitration and mid-transaction reset.
module tb_hyper_xface_wrapper;

    logic        clk;
    logic        i_reset;
    logic        i_rd_req;
    logic        i_wr_req;
    logic        i_mem_or_reg;
    logic [3:0]  i_wr_byte_en;
    logic [5:0]  i_rd_num_dwords;
    logic [31:0] i_addr;
    logic [31:0] i_wr_d;
    logic [31:0] o_rd_d;
    logic        o_rd_rdy;
    logic        o_busy;
    logic        o_burst_wr_rdy;
    logic [7:0]  i_latency_1x;
    logic [7:0]  i_latency_2x;

    int total = 0;
    int bad = 0;

    logic [7:0]  lat1 = 8'd7;
    logic [7:0]  lat2 = 8'd21;
    logic [31:0] rq[$];
    int          rcyc[$];
    int          busy_cyc;
    int          wr_p;
    int          rd_p;
    bit          tmo;

    hyper_xface_wrapper #(.DEPTH(1024), .CA_CYCLES(6)) dut (
        .i_clk           (clk),
        .i_reset         (i_reset),
        .i_rd_req        (i_rd_req),
        .i_wr_req        (i_wr_req),
        .i_mem_or_reg    (i_mem_or_reg),
        .i_wr_byte_en    (i_wr_byte_en),
        .i_rd_num_dwords (i_rd_num_dwords),
        .i_addr          (i_addr),
        .i_wr_d          (i_wr_d),
        .o_rd_d          (o_rd_d),
        .o_rd_rdy        (o_rd_rdy),
        .o_busy          (o_busy),
        .o_burst_wr_rdy  (o_burst_wr_rdy),
        .i_latency_1x    (i_latency_1x),
        .i_latency_2x    (i_latency_2x)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] qget(input int k);
        if (rq.size() > k) return rq[k];
        return 32'hxxxx_xxxx;
    endfunction

    // Runs one request; latency/address inputs are scrambled right after accept.
    task automatic txn(input bit rd, input bit wr, input bit mor, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be, input logic [5:0] n,
                       input int poke);
        rq.delete();
        rcyc.delete();
        busy_cyc = 0;
        wr_p = 0;
        rd_p = 0;
        tmo = 1'b1;
        @(negedge clk);
        i_rd_req        = rd;
        i_wr_req        = wr;
        i_mem_or_reg    = mor;
        i_addr          = a;
        i_wr_d          = wd;
        i_wr_byte_en    = be;
        i_rd_num_dwords = n;
        i_latency_1x    = lat1;
        i_latency_2x    = lat2;
        @(negedge clk);
        i_rd_req        = 1'b0;
        i_wr_req        = 1'b0;
        i_addr          = $urandom;
        i_wr_d          = $urandom;
        i_rd_num_dwords = 6'd17;
        i_latency_1x    = ~lat1;
        i_latency_2x    = ~lat2;
        for (int i = 0; i < 1000; i++) begin
            if (o_busy) busy_cyc++;
            if (o_burst_wr_rdy) wr_p++;
            if (o_rd_rdy) begin
                rd_p++;
                rq.push_back(o_rd_d);
                rcyc.push_back(i);
            end
            if (!o_busy) begin
                tmo = 1'b0;
                break;
            end
            if (i == poke) i_rd_req = 1'b1;
            @(negedge clk);
            i_rd_req = 1'b0;
        end
        repeat (3) begin
            @(negedge clk);
            if (o_burst_wr_rdy) wr_p++;
            if (o_rd_rdy) rd_p++;
        end
        i_latency_1x = lat1;
        i_latency_2x = lat2;
        chk("busy_timeout", 32'(tmo), 32'd0);
    endtask

    initial begin
        i_reset = 1'b0;
        i_rd_req = 1'b0;
        i_wr_req = 1'b0;
        i_mem_or_reg = 1'b0;
        i_wr_byte_en = 4'h0;
        i_rd_num_dwords = 6'd0;
        i_addr = 32'd0;
        i_wr_d = 32'd0;
        i_latency_1x = lat1;
        i_latency_2x = lat2;
        repeat (3) @(negedge clk);
        i_reset = 1'b1;
        @(negedge clk);

        // Reset values, then register reads (N forced to 1)
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_rd_rdy", 32'(o_rd_rdy), 32'd0);
        chk("rst_rd_d", o_rd_d, 32'd0);
        chk("rst_wr_rdy", 32'(o_burst_wr_rdy), 32'd0);
        txn(1, 0, 1, 32'd0, 32'd0, 4'h0, 6'd3, -1);
        chk("cr0_busy", busy_cyc, 32'd17);
        chk("cr0_pulses", rd_p, 32'd1);
        chk("cr0_data", qget(0), 32'h0000_8F1F);
        txn(1, 0, 1, 32'd1, 32'd0, 4'h0, 6'd0, -1);
        chk("cr1_data", qget(0), 32'h0000_0002);

        // Full-dword write and readback
        txn(0, 1, 0, 32'h42, 32'h0000_DEAD, 4'hF, 6'd0, -1);
        chk("wr42_busy", busy_cyc, 32'd31);
        chk("wr42_wrpulse", wr_p, 32'd1);
        chk("wr42_rdpulse", rd_p, 32'd0);
        txn(1, 0, 0, 32'h42, 32'd0, 4'h0, 6'd1, -1);
        chk("rd42_busy", busy_cyc, 32'd31);
        chk("rd42_pulses", rd_p, 32'd1);
        chk("rd42_data", qget(0), 32'h0000_DEAD);
        txn(1, 0, 0, 32'h0001_0042, 32'd0, 4'h0, 6'd1, -1);
        chk("rd42_hiaddr", qget(0), 32'h0000_DEAD);

        // Byte masks
        txn(0, 1, 0, 32'h10, 32'hFFFF_FFFF, 4'hF, 6'd0, -1);
        txn(0, 1, 0, 32'h10, 32'h1234_5678, 4'b0011, 6'd0, -1);
        txn(1, 0, 0, 32'h10, 32'd0, 4'h0, 6'd1, -1);
        chk("mask0011", qget(0), 32'hFFFF_5678);
        txn(0, 1, 0, 32'h10, 32'hFFFF_FFFF, 4'hF, 6'd0, -1);
        txn(0, 1, 0, 32'h10, 32'h1234_5678, 4'b0001, 6'd0, -1);
        txn(1, 0, 0, 32'h10, 32'd0, 4'h0, 6'd1, -1);
        chk("mask0001", qget(0), 32'hFFFF_FF78);

        // Wrapping burst of 4 from DEPTH-2
        txn(0, 1, 0, 32'h3FE, 32'hA5A5_03FE, 4'hF, 6'd0, -1);
        txn(0, 1, 0, 32'h3FF, 32'hA5A5_03FF, 4'hF, 6'd0, -1);
        txn(0, 1, 0, 32'h000, 32'hC0DE_0000, 4'hF, 6'd0, -1);
        txn(0, 1, 0, 32'h001, 32'hC0DE_0001, 4'hF, 6'd0, -1);
        txn(1, 0, 0, 32'h3FE, 32'd0, 4'h0, 6'd4, -1);
        chk("burst_busy", busy_cyc, 32'd43);
        chk("burst_pulses", rd_p, 32'd4);
        chk("burst_d0", qget(0), 32'hA5A5_03FE);
        chk("burst_d1", qget(1), 32'hA5A5_03FF);
        chk("burst_d2", qget(2), 32'hC0DE_0000);
        chk("burst_d3", qget(3), 32'hC0DE_0001);
        if (rcyc.size() == 4) begin
            chk("burst_gap1", rcyc[1] - rcyc[0], 32'd4);
            chk("burst_gap3", rcyc[3] - rcyc[2], 32'd4);
        end else begin
            chk("burst_gap_count", rcyc.size(), 32'd4);
        end

        // Simultaneous requests: write wins; read pulse while busy ignored
        txn(1, 1, 0, 32'h20, 32'h5555_AAAA, 4'hF, 6'd1, -1);
        chk("both_busy", busy_cyc, 32'd31);
        chk("both_wrpulse", wr_p, 32'd1);
        chk("both_rdpulse", rd_p, 32'd0);
        txn(1, 0, 0, 32'h20, 32'd0, 4'h0, 6'd1, 5);
        chk("poke_pulses", rd_p, 32'd1);
        chk("poke_busy", busy_cyc, 32'd31);
        chk("both_data", qget(0), 32'h5555_AAAA);

        // Register write ignores byte enables and has no latency
        txn(0, 1, 1, 32'd0, 32'hABCD_1234, 4'h0, 6'd0, -1);
        chk("crwr_busy", busy_cyc, 32'd10);
        chk("crwr_wrpulse", wr_p, 32'd1);
        txn(1, 0, 1, 32'd0, 32'd0, 4'h0, 6'd0, -1);
        chk("crwr_data", qget(0), 32'h0000_1234);

        // Reset in the middle of a write's latency phase
        @(negedge clk);
        i_wr_req = 1'b1;
        i_mem_or_reg = 1'b0;
        i_addr = 32'h42;
        i_wr_d = 32'h1111_1111;
        i_wr_byte_en = 4'hF;
        @(negedge clk);
        i_wr_req = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid_busy_pre", 32'(o_busy), 32'd1);
        i_reset = 1'b0;
        @(negedge clk);
        chk("mid_busy", 32'(o_busy), 32'd0);
        chk("mid_rd_d", o_rd_d, 32'd0);
        chk("mid_rd_rdy", 32'(o_rd_rdy), 32'd0);
        chk("mid_wr_rdy", 32'(o_burst_wr_rdy), 32'd0);
        i_reset = 1'b1;
        repeat (40) @(negedge clk);
        chk("mid_idle", 32'(o_busy), 32'd0);
        txn(1, 0, 0, 32'h42, 32'd0, 4'h0, 6'd1, -1);
        chk("mid_target", qget(0), 32'h0000_DEAD);
        txn(1, 0, 1, 32'd0, 32'd0, 4'h0, 6'd0, -1);
        chk("mid_cr0", qget(0), 32'h0000_8F1F);

        // Zero memory latency
        lat2 = 8'd0;
        txn(0, 1, 0, 32'h50, 32'h0BAD_F00D, 4'hF, 6'd0, -1);
        chk("l0_wr_busy", busy_cyc, 32'd10);
        txn(1, 0, 0, 32'h50, 32'd0, 4'h0, 6'd1, -1);
        chk("l0_rd_busy", busy_cyc, 32'd10);
        chk("l0_rd_data", qget(0), 32'h0BAD_F00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
